// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage MIPS pipeline (between ex_mem
// and mem_wb).
//
// Loads and stores go out over a single-outstanding req/ack data-memory bus.
// While a transfer is in flight the stage raises stall_req to hold the earlier
// pipeline stages. Non-memory instructions pass straight through with no added
// latency. Byte order is big-endian: lane 3 (dm_sel[3]) carries bits [31:24].
//
// Ports:
//   clk, rst            pipeline clock, asynchronous active-high reset
//   ex_wd/ex_wreg/ex_wdata    write-back triple from ex_mem
//   ex_mem_op           0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH,
//                       8 SW; 9-15 are treated as none
//   ex_mem_addr         effective byte address
//   ex_store_data       rt value for stores
//   dm_req/dm_we/dm_addr/dm_sel/dm_wdata   registered bus request
//   dm_rdata/dm_ack     bus response; dm_ack is a one-cycle completion strobe
//   stall_req           combinational hold of the earlier stages
//   align_err/bus_err   one-cycle error pulses (misaligned access / ack timeout)
//   mem_wd/mem_wreg/mem_wdata  write-back triple to mem_wb
module mem_stage #(
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_store_data,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_sel,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        stall_req,
  output logic        align_err,
  output logic        bus_err,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LW);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic op_is_misaligned(input logic [3:0] op, input logic [1:0] off);
    logic mis;
    case (op)
      OP_LH, OP_LHU, OP_SH: mis = off[0];
      OP_LW, OP_SW:         mis = (off != 2'b00);
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Big-endian lane enables: offset 0 is the most significant byte.
  function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] off);
    logic [3:0] sel;
    case (op)
      OP_LB, OP_LBU, OP_SB: begin
        case (off)
          2'b00:   sel = 4'b1000;
          2'b01:   sel = 4'b0100;
          2'b10:   sel = 4'b0010;
          default: sel = 4'b0001;
        endcase
      end
      OP_LH, OP_LHU, OP_SH: sel = off[1] ? 4'b0011 : 4'b1100;
      OP_LW, OP_SW:         sel = 4'b1111;
      default:              sel = 4'b0000;
    endcase
    return sel;
  endfunction

  // Stores replicate the datum across every lane; dm_sel picks the live one.
  function automatic logic [31:0] store_rep(input logic [3:0] op, input logic [31:0] d);
    logic [31:0] r;
    case (op)
      OP_SB:   r = {4{d[7:0]}};
      OP_SH:   r = {2{d[15:0]}};
      OP_SW:   r = d;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] off,
                                               input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = rd[31:24];
      2'b01:   b = rd[23:16];
      2'b10:   b = rd[15:8];
      default: b = rd[7:0];
    endcase
    h = off[1] ? rd[15:0] : rd[31:16];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'h00_0000, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'h0000, h};
      OP_LW:   r = rd;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic              dm_req_q, dm_req_d;
  logic              dm_we_q, dm_we_d;
  logic [31:0]       dm_addr_q, dm_addr_d;
  logic [3:0]        dm_sel_q, dm_sel_d;
  logic [31:0]       dm_wdata_q, dm_wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic              align_err_q, align_err_d;
  logic              bus_err_q, bus_err_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        off_q, off_d;

  logic              ex_is_mem_s;
  logic              ex_mis_s;

  assign ex_is_mem_s = op_is_load(ex_mem_op) || op_is_store(ex_mem_op);
  assign ex_mis_s    = op_is_misaligned(ex_mem_op, ex_mem_addr[1:0]);

  // Next-state logic for the transfer FSM and its registered bus outputs.
  always_comb begin
    state_d     = state_q;
    dm_req_d    = dm_req_q;
    dm_we_d     = dm_we_q;
    dm_addr_d   = dm_addr_q;
    dm_sel_d    = dm_sel_q;
    dm_wdata_d  = dm_wdata_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    err_d       = err_q;
    op_d        = op_q;
    off_d       = off_q;
    align_err_d = 1'b0;
    bus_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ex_is_mem_s && !ex_mis_s) begin
          dm_req_d   = 1'b1;
          dm_we_d    = op_is_store(ex_mem_op);
          dm_addr_d  = {ex_mem_addr[31:2], 2'b00};
          dm_sel_d   = lane_sel(ex_mem_op, ex_mem_addr[1:0]);
          dm_wdata_d = store_rep(ex_mem_op, ex_store_data);
          cnt_d      = '0;
          err_d      = 1'b0;
          op_d       = ex_mem_op;
          off_d      = ex_mem_addr[1:0];
          state_d    = S_BUSY;
        end else if (ex_is_mem_s) begin
          // Misaligned: dropped without touching the bus.
          align_err_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        // An ack on the expiry cycle wins over the timeout.
        if (dm_ack) begin
          dm_req_d = 1'b0;
          data_d   = load_extract(op_q, off_q, dm_rdata);
          state_d  = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          dm_req_d  = 1'b0;
          bus_err_d = 1'b1;
          err_d     = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        dm_req_d = 1'b0;
      end
    endcase
  end

  // State and bus-output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dm_req_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= 32'h0000_0000;
      dm_sel_q    <= 4'b0000;
      dm_wdata_q  <= 32'h0000_0000;
      cnt_q       <= '0;
      data_q      <= 32'h0000_0000;
      err_q       <= 1'b0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
      op_q        <= 4'd0;
      off_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      dm_req_q    <= dm_req_d;
      dm_we_q     <= dm_we_d;
      dm_addr_q   <= dm_addr_d;
      dm_sel_q    <= dm_sel_d;
      dm_wdata_q  <= dm_wdata_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      err_q       <= err_d;
      align_err_q <= align_err_d;
      bus_err_q   <= bus_err_d;
      op_q        <= op_d;
      off_q       <= off_d;
    end
  end

  // Write-back triple and pipeline hold. Reset forces the hold and the write
  // enable low right away, even while the memory op is still on ex_mem.
  always_comb begin
    mem_wd    = ex_wd;
    mem_wdata = ex_wdata;
    mem_wreg  = 1'b0;
    stall_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!ex_is_mem_s) begin
          mem_wreg = ex_wreg;
        end else if (!ex_mis_s) begin
          stall_req = 1'b1;
        end else begin
          mem_wreg = 1'b0;
        end
      end
      S_BUSY: begin
        stall_req = 1'b1;
      end
      S_DONE: begin
        if (op_is_load(op_q) && !err_q) begin
          mem_wreg  = ex_wreg;
          mem_wdata = data_q;
        end else begin
          mem_wreg = 1'b0;
        end
      end
      default: begin
        stall_req = 1'b0;
      end
    endcase
    if (rst) begin
      stall_req = 1'b0;
      mem_wreg  = 1'b0;
    end else begin
      stall_req = stall_req;
    end
  end

  assign dm_req    = dm_req_q;
  assign dm_we     = dm_we_q;
  assign dm_addr   = dm_addr_q;
  assign dm_sel    = dm_sel_q;
  assign dm_wdata  = dm_wdata_q;
  assign align_err = align_err_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage (ACK_TIMEOUT = 4). Inputs change 1 time
// unit after each rising edge; outputs are checked 1 unit later.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_sel;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        stall_req, align_err, bus_err;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;

  int n_vec = 0;
  int n_err = 0;

  mem_stage #(.ACK_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_sel(dm_sel),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .stall_req(stall_req), .align_err(align_err), .bus_err(bus_err),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One memory transfer from IDLE through DONE. ack_at = BUSY cycle (1-based)
  // in which dm_ack is raised; 0 means never (timeout after 4 BUSY cycles).
  task automatic mem_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] rd, input int ack_at,
                        input logic [3:0] esel, input logic ewe, input logic [31:0] edw,
                        input logic ewreg, input logic [31:0] ewdata, input logic ebus);
    int  c;
    bit  fin;
    ex_mem_op = op; ex_mem_addr = addr; ex_store_data = sd;
    ex_wd = 5'd9; ex_wreg = 1'b1; ex_wdata = 32'hDEAD_0000;
    #1;
    chk({tag, " idle stall"}, {31'd0, stall_req}, 32'd1);
    chk({tag, " idle wreg"}, {31'd0, mem_wreg}, 32'd0);
    c = 1; fin = 1'b0;
    while (!fin) begin
      step();
      chk({tag, " busy req"}, {31'd0, dm_req}, 32'd1);
      chk({tag, " busy stall"}, {31'd0, stall_req}, 32'd1);
      chk({tag, " busy wreg"}, {31'd0, mem_wreg}, 32'd0);
      chk({tag, " sel"}, {28'd0, dm_sel}, {28'd0, esel});
      chk({tag, " we"}, {31'd0, dm_we}, {31'd0, ewe});
      chk({tag, " addr"}, dm_addr, {addr[31:2], 2'b00});
      if (ewe) chk({tag, " wdata"}, dm_wdata, edw);
      if (c == ack_at) begin
        dm_ack = 1'b1; dm_rdata = rd;
      end
      if (c == ack_at || c == 4) fin = 1'b1;
      c++;
    end
    step();
    dm_ack = 1'b0; dm_rdata = 32'h0000_0000;
    #1;
    chk({tag, " done stall"}, {31'd0, stall_req}, 32'd0);
    chk({tag, " done req"}, {31'd0, dm_req}, 32'd0);
    chk({tag, " done wreg"}, {31'd0, mem_wreg}, {31'd0, ewreg});
    chk({tag, " done wd"}, {27'd0, mem_wd}, 32'd9);
    if (ewreg) chk({tag, " done wdata"}, mem_wdata, ewdata);
    chk({tag, " done bus_err"}, {31'd0, bus_err}, {31'd0, ebus});
    step();
    ex_mem_op = 4'd0; ex_wreg = 1'b0;
    #1;
    chk({tag, " idle again stall"}, {31'd0, stall_req}, 32'd0);
    chk({tag, " bus_err cleared"}, {31'd0, bus_err}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    ex_wd = 5'd0; ex_wreg = 1'b0; ex_wdata = 32'h0; ex_mem_op = 4'd0;
    ex_mem_addr = 32'h0; ex_store_data = 32'h0; dm_rdata = 32'h0; dm_ack = 1'b0;
    #3;
    chk("reset dm_req", {31'd0, dm_req}, 32'd0);
    chk("reset stall", {31'd0, stall_req}, 32'd0);
    chk("reset dm_addr", dm_addr, 32'h0);
    chk("reset dm_sel", {28'd0, dm_sel}, 32'd0);
    chk("reset errs", {30'd0, align_err, bus_err}, 32'd0);
    step();
    rst = 1'b0;

    // Pass-through
    ex_mem_op = 4'd0; ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678;
    #1;
    chk("pass wd", {27'd0, mem_wd}, 32'd3);
    chk("pass wreg", {31'd0, mem_wreg}, 32'd1);
    chk("pass wdata", mem_wdata, 32'h1234_5678);
    chk("pass stall", {31'd0, stall_req}, 32'd0);
    ex_mem_op = 4'd12;
    #1;
    chk("op12 pass wreg", {31'd0, mem_wreg}, 32'd1);
    step();
    chk("pass no req", {31'd0, dm_req}, 32'd0);

    // Loads: byte at offset 1, ack in 3rd BUSY cycle
    mem_op("LB", 4'd1, 32'h0000_0101, 32'h0, 32'h11F2_3344, 3, 4'b0100, 1'b0, 32'h0,
           1'b1, 32'hFFFF_FFF2, 1'b0);
    mem_op("LBU", 4'd2, 32'h0000_0101, 32'h0, 32'h11F2_3344, 3, 4'b0100, 1'b0, 32'h0,
           1'b1, 32'h0000_00F2, 1'b0);
    mem_op("LH", 4'd3, 32'h0000_0202, 32'h0, 32'h1234_8765, 1, 4'b0011, 1'b0, 32'h0,
           1'b1, 32'hFFFF_8765, 1'b0);
    mem_op("LHU", 4'd4, 32'h0000_0300, 32'h0, 32'h8765_1234, 1, 4'b1100, 1'b0, 32'h0,
           1'b1, 32'h0000_8765, 1'b0);
    // Ack on the timeout-expiry cycle still succeeds
    mem_op("LW late ack", 4'd5, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 4, 4'b1111, 1'b0, 32'h0,
           1'b1, 32'hCAFE_F00D, 1'b0);

    // Stores
    mem_op("SH", 4'd7, 32'h0000_0010, 32'hAAAA_BEEF, 32'h0, 2, 4'b1100, 1'b1, 32'hBEEF_BEEF,
           1'b0, 32'h0, 1'b0);
    mem_op("SB", 4'd6, 32'h0000_0023, 32'h0000_00A5, 32'h0, 1, 4'b0001, 1'b1, 32'hA5A5_A5A5,
           1'b0, 32'h0, 1'b0);

    // Timeout: SW never acknowledged
    mem_op("SW timeout", 4'd8, 32'h0000_0080, 32'h0102_0304, 32'h0, 0, 4'b1111, 1'b1,
           32'h0102_0304, 1'b0, 32'h0, 1'b1);

    // Misaligned LW
    ex_mem_op = 4'd5; ex_mem_addr = 32'h0000_0006; ex_wreg = 1'b1; ex_wd = 5'd4;
    #1;
    chk("mis stall", {31'd0, stall_req}, 32'd0);
    chk("mis wreg", {31'd0, mem_wreg}, 32'd0);
    step();
    ex_mem_op = 4'd0; ex_wreg = 1'b0;
    #1;
    chk("mis align_err", {31'd0, align_err}, 32'd1);
    chk("mis no req", {31'd0, dm_req}, 32'd0);
    step();
    chk("mis align_err pulse", {31'd0, align_err}, 32'd0);
    chk("mis still no req", {31'd0, dm_req}, 32'd0);

    // Reset in the middle of a transfer
    ex_mem_op = 4'd5; ex_mem_addr = 32'h0000_0020; ex_wreg = 1'b1;
    step();
    chk("rst pre req", {31'd0, dm_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst req drop", {31'd0, dm_req}, 32'd0);
    chk("rst stall drop", {31'd0, stall_req}, 32'd0);
    chk("rst wreg drop", {31'd0, mem_wreg}, 32'd0);
    step();
    rst = 1'b0; ex_mem_op = 4'd0; ex_wreg = 1'b0;
    dm_ack = 1'b1; dm_rdata = 32'h5555_5555;
    #1;
    chk("late ack wreg", {31'd0, mem_wreg}, 32'd0);
    step();
    dm_ack = 1'b0;
    #1;
    chk("late ack req", {31'd0, dm_req}, 32'd0);
    chk("late ack stall", {31'd0, stall_req}, 32'd0);
    chk("late ack wreg after", {31'd0, mem_wreg}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
